// File: rtl/kfmmc_data_line_shifter.sv
// KFMMC DAT0 bit engine: shifts one byte MSB first on DAT0, generates mmc_clock and runs CRC16.
// Optional start-bit timeout is built when KFMMC_DATA_START_BIT_TIMEOUT_EN is defined.
module kfmmc_data_line_shifter #(
  parameter int MMC_CLOCK_DIV     = 2,
  parameter int START_BIT_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_communication,
  input  logic        data_io,
  input  logic        check_data_start_bit,
  input  logic        clear_data_crc,
  input  logic        clear_data_interrupt,
  input  logic        mask_data_interrupt,
  input  logic        set_send_data,
  input  logic [7:0]  send_data,
  output logic [7:0]  received_data,
  output logic        in_connecting,
  output logic        sent_data_interrupt,
  output logic        received_data_interrupt,
  output logic [15:0] data_crc,
  output logic        mmc_clock,
  output logic        mmc_dat_out,
  output logic        mmc_dat_io,
  input  logic        mmc_dat_in,
  output logic        start_bit_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT, DONE} state_t;

  localparam int             DW       = (MMC_CLOCK_DIV > 1) ? $clog2(MMC_CLOCK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(MMC_CLOCK_DIV - 1);
  localparam logic [15:0]    CRC_POLY = 16'h1021;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          dir_rx_q, dir_rx_d;
  logic          start_seen_q, start_seen_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    received_q, received_d;
  logic [15:0]   crc_q, crc_d;
  logic          in_conn_q, in_conn_d;
  logic          sent_irq_q, sent_irq_d;
  logic          recv_irq_q, recv_irq_d;
  logic          clk_q, clk_d;
  logic          dat_out_q, dat_out_d;
  logic          dat_io_q, dat_io_d;
  logic          div_wrap;

`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
  localparam int TW = $clog2(START_BIT_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_flag_q, tmo_flag_d;
`endif

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    div_d        = div_q;
    bit_cnt_d    = bit_cnt_q;
    dir_rx_d     = dir_rx_q;
    start_seen_d = start_seen_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    received_d   = received_q;
    crc_d        = crc_q;
    sent_irq_d   = sent_irq_q;
    recv_irq_d   = recv_irq_q;
    clk_d        = clk_q;
    dat_out_d    = dat_out_q;
    dat_io_d     = dat_io_q;
`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_flag_d   = tmo_flag_q;
    if (clear_data_interrupt) tmo_flag_d = 1'b0;
`endif

    // Clear first so a completion in the same cycle overrides it.
    if (clear_data_interrupt) begin
      sent_irq_d = 1'b0;
      recv_irq_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (set_send_data) tx_d = send_data;
        if (start_communication) begin
          dir_rx_d     = data_io;
          start_seen_d = 1'b0;
          div_d        = '0;
          bit_cnt_d    = '0;
          clk_d        = 1'b0;
          if (clear_data_crc) crc_d = 16'h0000;
          if (data_io) begin
            dat_io_d = 1'b0;
            state_d  = check_data_start_bit ? WAIT_START : SHIFT;
`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            dat_io_d  = 1'b1;
            dat_out_d = tx_d[7];
            state_d   = SHIFT;
          end
        end
      end

      WAIT_START: begin
        div_d = div_q + 1'b1;
        if (div_wrap) begin
          div_d = '0;
          clk_d = ~clk_q;
          if (!clk_q) begin
            if (!mmc_dat_in) begin
              start_seen_d = 1'b1;
            end
`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
            else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
              if (tmo_cnt_d == TW'(START_BIT_TIMEOUT)) begin
                state_d    = IDLE;
                tmo_flag_d = 1'b1;
              end
            end
`endif
          end else if (start_seen_q) begin
            // The falling edge after the start bit opens data bit 7.
            state_d   = SHIFT;
            bit_cnt_d = '0;
          end
        end
      end

      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_wrap) begin
          div_d = '0;
          if (!clk_q) begin
            clk_d     = 1'b1;
            crc_d     = crc_step(crc_q, dir_rx_q ? mmc_dat_in : dat_out_q);
            rx_d      = {rx_q[6:0], mmc_dat_in};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == 4'd8) begin
            state_d = DONE;
          end else begin
            clk_d = 1'b0;
            if (!dir_rx_q) dat_out_d = tx_q[3'd7 - bit_cnt_q[2:0]];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (dir_rx_q) begin
          received_d = rx_q;
          recv_irq_d = 1'b1;
        end else begin
          sent_irq_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    in_conn_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      dir_rx_q     <= 1'b0;
      start_seen_q <= 1'b0;
      tx_q         <= 8'hFF;
      rx_q         <= 8'h00;
      received_q   <= 8'h00;
      crc_q        <= 16'h0000;
      in_conn_q    <= 1'b0;
      sent_irq_q   <= 1'b0;
      recv_irq_q   <= 1'b0;
      clk_q        <= 1'b1;
      dat_out_q    <= 1'b1;
      dat_io_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q      <= state_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      dir_rx_q     <= dir_rx_d;
      start_seen_q <= start_seen_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      received_q   <= received_d;
      crc_q        <= crc_d;
      in_conn_q    <= in_conn_d;
      sent_irq_q   <= sent_irq_d;
      recv_irq_q   <= recv_irq_d;
      clk_q        <= clk_d;
      dat_out_q    <= dat_out_d;
      dat_io_q     <= dat_io_d;
    end
  end

`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
  assign start_bit_timeout = tmo_flag_q;
`else
  assign start_bit_timeout = 1'b0;
`endif

  assign received_data           = received_q;
  assign in_connecting           = in_conn_q;
  assign sent_data_interrupt     = sent_irq_q & ~mask_data_interrupt;
  assign received_data_interrupt = recv_irq_q & ~mask_data_interrupt;
  assign data_crc                = crc_q;
  assign mmc_clock               = clk_q;
  assign mmc_dat_out             = dat_out_q;
  assign mmc_dat_io              = dat_io_q;

endmodule

// File: tb/tb_kfmmc_data_line_shifter.sv
// Scoreboard bench for kfmmc_data_line_shifter: random byte transfers against a CRC-by-division model.
// The timeout scenario runs when KFMMC_DATA_START_BIT_TIMEOUT_EN is defined.
module tb_kfmmc_data_line_shifter;

  localparam int DIV = 2;
`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_communication = 1'b0;
  logic        data_io = 1'b0;
  logic        check_data_start_bit = 1'b0;
  logic        clear_data_crc = 1'b0;
  logic        clear_data_interrupt = 1'b0;
  logic        mask_data_interrupt = 1'b0;
  logic        set_send_data = 1'b0;
  logic [7:0]  send_data = 8'h00;
  logic [7:0]  received_data;
  logic        in_connecting;
  logic        sent_data_interrupt;
  logic        received_data_interrupt;
  logic [15:0] data_crc;
  logic        mmc_clock;
  logic        mmc_dat_out;
  logic        mmc_dat_io;
  logic        mmc_dat_in = 1'b1;
  logic        start_bit_timeout;

  kfmmc_data_line_shifter #(.MMC_CLOCK_DIV(DIV), .START_BIT_TIMEOUT(TMO)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .start_communication     (start_communication),
    .data_io                 (data_io),
    .check_data_start_bit    (check_data_start_bit),
    .clear_data_crc          (clear_data_crc),
    .clear_data_interrupt    (clear_data_interrupt),
    .mask_data_interrupt     (mask_data_interrupt),
    .set_send_data           (set_send_data),
    .send_data               (send_data),
    .received_data           (received_data),
    .in_connecting           (in_connecting),
    .sent_data_interrupt     (sent_data_interrupt),
    .received_data_interrupt (received_data_interrupt),
    .data_crc                (data_crc),
    .mmc_clock               (mmc_clock),
    .mmc_dat_out             (mmc_dat_out),
    .mmc_dat_io              (mmc_dat_io),
    .mmc_dat_in              (mmc_dat_in),
    .start_bit_timeout       (start_bit_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rx;
    logic [7:0]  data;
    logic [15:0] crc;
    logic        irq;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          skip_fall = 0;
  logic        prev_ic = 1'b0;
  logic [15:0] crc_model = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of (crc*x^8 + byte*x^16) divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_after(input logic [15:0] crc_in, input logic [7:0] b);
    logic [23:0] r;
    logic [23:0] poly;
    r = {crc_in, 8'h00} ^ {b, 16'h0000};
    for (int i = 23; i >= 16; i--) begin
      poly = 24'h011021 << (i - 16);
      if (r[i]) r = r ^ poly;
    end
    return r[15:0];
  endfunction

  // Monitor: every completed transfer shows up as a falling in_connecting.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_ic = 1'b0;
    end else begin
      if (prev_ic && !in_connecting) begin
        if (skip_fall) begin
          skip_fall = 0;
        end else if (sb_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.rx) begin
            check("rx_data", received_data, mon_e.data);
            check("rx_irq", received_data_interrupt, mon_e.irq);
            check("rx_dat_io", mmc_dat_io, 0);
          end else begin
            check("tx_irq", sent_data_interrupt, mon_e.irq);
            check("tx_dat_io", mmc_dat_io, 1);
          end
          check("crc", data_crc, mon_e.crc);
        end
      end
      prev_ic = in_connecting;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_received_data"}, received_data, 8'h00);
    check({tag, "_crc"}, data_crc, 16'h0000);
    check({tag, "_in_connecting"}, in_connecting, 0);
    check({tag, "_sent_irq"}, sent_data_interrupt, 0);
    check({tag, "_recv_irq"}, received_data_interrupt, 0);
    check({tag, "_mmc_clock"}, mmc_clock, 1);
    check({tag, "_dat_out"}, mmc_dat_out, 1);
    check({tag, "_dat_io"}, mmc_dat_io, 0);
    check({tag, "_timeout"}, start_bit_timeout, 0);
  endtask

  task automatic clear_irqs();
    @(negedge clock); clear_data_interrupt = 1'b1;
    @(negedge clock); clear_data_interrupt = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] b);
    @(negedge clock); set_send_data = 1'b1; send_data = b;
    @(negedge clock); set_send_data = 1'b0;
  endtask

  task automatic pulse_start(input logic rx, input logic chk, input logic clr);
    @(negedge clock);
    data_io = rx; check_data_start_bit = chk; clear_data_crc = clr; start_communication = 1'b1;
    @(posedge clock); #1;
    start_communication = 1'b0; check_data_start_bit = 1'b0; clear_data_crc = 1'b0;
  endtask

  task automatic do_send(input logic [7:0] b, input logic clr, input logic irq_exp,
                         input bit hold_clr, output int ic);
    exp_t e;
    logic prev_clk;
    int   nfall;
    clear_irqs();
    load_tx(b);
    if (clr) crc_model = 16'h0000;
    crc_model = crc_after(crc_model, b);
    e.rx = 1'b0; e.data = b; e.crc = crc_model; e.irq = irq_exp;
    sb_q.push_back(e);
    if (hold_clr) clear_data_interrupt = 1'b1;
    pulse_start(1'b0, 1'b0, clr);
    prev_clk = 1'b1; nfall = 0; ic = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (prev_clk && !mmc_clock) begin
        if (nfall < 8) check("tx_bit", mmc_dat_out, b[7 - nfall]);
        else check("tx_extra_fall", nfall, 7);
        nfall++;
      end
      prev_clk = mmc_clock;
      if (!in_connecting) break;
      ic++;
      @(posedge clock); #1;
    end
    clear_data_interrupt = 1'b0;
    check("tx_done_in_time", in_connecting, 0);
    check("tx_fall_count", nfall, 8);
  endtask

  task automatic do_recv(input logic [7:0] b, input logic chk, input logic clr, input int pre_ones);
    exp_t e;
    logic bits[$];
    logic prev_clk;
    clear_irqs();
    if (clr) crc_model = 16'h0000;
    crc_model = crc_after(crc_model, b);
    e.rx = 1'b1; e.data = b; e.crc = crc_model; e.irq = 1'b1;
    sb_q.push_back(e);
    if (chk) begin
      for (int i = 0; i < pre_ones; i++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
    mmc_dat_in = 1'b1;
    pulse_start(1'b1, chk, clr);
    prev_clk = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (prev_clk && !mmc_clock) mmc_dat_in = (bits.size() != 0) ? bits.pop_front() : 1'b1;
      prev_clk = mmc_clock;
      if (!in_connecting) break;
      @(posedge clock); #1;
    end
    mmc_dat_in = 1'b1;
    check("rx_done_in_time", in_connecting, 0);
    check("rx_bits_consumed", bits.size(), 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ic;
    logic [7:0]  b;
    logic        prev_clk;
    int          nfall;

    #23;
    check_reset_vals("reset");
    @(negedge clock); reset_n = 1'b1;

    // Directed send of 0xAB from a cleared CRC.
    do_send(8'hAB, 1'b1, 1'b1, 0, ic);
    check("tx_in_connecting_cycles", ic, 33);
    check("tx_crc_ab", data_crc, crc_after(16'h0000, 8'hAB));
    check("tx_crc_ab_const", data_crc, 16'h0481);
    @(negedge clock); #1;

    // Plain receive and start-bit receive.
    do_recv(8'hCD, 1'b0, 1'b0, 0);
    @(negedge clock); #1;
    do_recv(8'hDC, 1'b1, 1'b1, 5);
    @(negedge clock); #1;
    check("rx_dc_crc_only", data_crc, crc_after(16'h0000, 8'hDC));

    // Masked completion: flag latches behind the mask.
    mask_data_interrupt = 1'b1;
    do_send(8'h96, 1'b0, 1'b0, 0, ic);
    @(negedge clock); #1;
    check("masked_sent_irq", sent_data_interrupt, 0);
    mask_data_interrupt = 1'b0; #1;
    check("unmasked_sent_irq", sent_data_interrupt, 1);
    clear_irqs(); #1;
    check("cleared_sent_irq", sent_data_interrupt, 0);
    check("cleared_recv_irq", received_data_interrupt, 0);

    // Clear held across completion: set must win.
    do_send(8'h3E, 1'b0, 1'b1, 1, ic);
    @(negedge clock); #1;

    // Randomized mix of transfers.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_send(b, 1'($urandom_range(0, 1)), 1'b1, 0, ic);
        check("rand_tx_ic", ic, 33);
      end else begin
        do_recv(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      end
      @(negedge clock); #1;
    end

    // Reset in the middle of SHIFT after three bits.
    load_tx(8'h3C);
    pulse_start(1'b0, 1'b0, 1'b0);
    prev_clk = 1'b1; nfall = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (prev_clk && !mmc_clock) nfall++;
      prev_clk = mmc_clock;
      if (nfall == 4) break;
      @(posedge clock); #1;
    end
    check("abort_reached_bit3", nfall, 4);
    reset_n = 1'b0; #2;
    check_reset_vals("abort");
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    crc_model = 16'h0000;
    do_send(8'h5A, 1'b0, 1'b1, 0, ic);
    check("post_reset_ic", ic, 33);
    @(negedge clock); #1;

`ifdef KFMMC_DATA_START_BIT_TIMEOUT_EN
    begin
      logic [7:0] rd;
      int         rises;
      clear_irqs();
      rd = received_data;
      skip_fall = 1;
      mmc_dat_in = 1'b1;
      pulse_start(1'b1, 1'b1, 1'b0);
      prev_clk = 1'b0; rises = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (!prev_clk && mmc_clock) rises++;
        prev_clk = mmc_clock;
        if (!in_connecting) break;
        @(posedge clock); #1;
      end
      check("tmo_done_in_time", in_connecting, 0);
      check("tmo_rises", rises, TMO);
      check("tmo_flag", start_bit_timeout, 1);
      check("tmo_no_recv_irq", received_data_interrupt, 0);
      check("tmo_rx_unchanged", received_data, rd);
      check("tmo_clock_idle", mmc_clock, 1);
      @(negedge clock); @(negedge clock);
      clear_irqs(); #1;
      check("tmo_cleared", start_bit_timeout, 0);
    end
`else
    check("timeout_tied_low", start_bit_timeout, 0);
`endif

    repeat (4) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
